// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter sharing one UART transmitter among p_REQUESTERS byte sources.
// Latency: a request sampled in IDLE gives registered o_tx_start/o_ack in the next cycle; busy watchdog is p_BUSY_TIMEOUT cycles.
// Backpressure: requesters hold i_req until o_ack; a new grant waits for the transmitter's busy flag to fall, or for the watchdog.
// Optional feature: define UART_TX_ARB_LOCK_EN to keep the grant for a whole packet, up to the byte flagged by i_last.
module uart_tx_arbiter #(
    parameter int p_REQUESTERS   = 4,
    parameter int p_DATA_BITS    = 8,
    parameter int p_BUSY_TIMEOUT = 15
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [p_REQUESTERS-1:0]               i_req,
    input  logic [p_REQUESTERS*p_DATA_BITS-1:0]   i_data,
    input  logic [p_REQUESTERS-1:0]               i_last,
    output logic [p_REQUESTERS-1:0]               o_ack,
    output logic [p_REQUESTERS-1:0]               o_grant,
    output logic [p_DATA_BITS-1:0]                o_tx_data,
    output logic                                  o_tx_start,
    input  logic                                  i_tx_busy,
    output logic                                  o_err
);

    localparam int PW = $clog2(p_REQUESTERS);
`ifdef UART_TX_ARB_LOCK_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif
    localparam logic [PW-1:0] PTR_RST  = PW'(p_REQUESTERS - 1);
    localparam logic [7:0]    TMO_LOAD = 8'(p_BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t                    state_q;
    logic [PW-1:0]             ptr_q;
    logic [PW-1:0]             gidx_q;
    logic [7:0]                cnt_q;
    logic                      lock_q;
    logic                      last_q;
    logic [p_REQUESTERS-1:0]   ack_q;
    logic [p_REQUESTERS-1:0]   grant_q;
    logic [p_DATA_BITS-1:0]    tx_data_q;
    logic                      tx_start_q;
    logic                      err_q;

    logic [p_REQUESTERS-1:0]   elig_d;
    logic [p_REQUESTERS-1:0]   pick_oh_d;
    logic [PW-1:0]             pick_idx_d;
    logic                      pick_vld_d;
    logic [p_DATA_BITS-1:0]    pick_data_d;
    logic                      pick_last_d;
    logic [PW:0]               scan_d;

    // Round-robin pick: first eligible requester after ptr_q, with wrap.
    // Scanning from the farthest position down lets the nearest one win by overwrite.
    always_comb begin
        elig_d      = lock_q ? (i_req & grant_q) : i_req;
        pick_vld_d  = 1'b0;
        pick_idx_d  = '0;
        scan_d      = '0;
        for (int i = p_REQUESTERS; i >= 1; i--) begin
            scan_d = {1'b0, ptr_q} + (PW+1)'(i);
            if (scan_d >= (PW+1)'(p_REQUESTERS)) begin
                scan_d = scan_d - (PW+1)'(p_REQUESTERS);
            end
            if (elig_d[scan_d[PW-1:0]]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = scan_d[PW-1:0];
            end
        end
        pick_oh_d             = '0;
        pick_oh_d[pick_idx_d] = 1'b1;
        pick_data_d           = '0;
        pick_last_d           = 1'b0;
        for (int k = 0; k < p_REQUESTERS; k++) begin
            if (pick_idx_d == PW'(k)) begin
                pick_data_d = i_data[k*p_DATA_BITS +: p_DATA_BITS];
                pick_last_d = i_last[k];
            end
        end
    end

    // Transfer FSM with registered outputs: grant, start pulse, busy watchdog, completion.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= PTR_RST;
            gidx_q     <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            last_q     <= 1'b0;
            ack_q      <= '0;
            grant_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        state_q    <= S_START;
                        gidx_q     <= pick_idx_d;
                        grant_q    <= pick_oh_d;
                        ack_q      <= pick_oh_d;
                        tx_start_q <= 1'b1;
                        tx_data_q  <= pick_data_d;
                        last_q     <= pick_last_d;
                        lock_q     <= LOCK_EN;
                    end
                end
                S_START: begin
                    cnt_q   <= TMO_LOAD;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (cnt_q <= 8'd1) begin
                        // Transmitter never answered: report, release any lock, move on.
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                        ptr_q   <= gidx_q;
                        lock_q  <= 1'b0;
                        grant_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        state_q <= S_IDLE;
                        ptr_q   <= gidx_q;
                        if (!lock_q || last_q) begin
                            lock_q  <= 1'b0;
                            grant_q <= '0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ack      = ack_q;
    assign o_grant    = grant_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues and a transmitter model drive the DUT,
// a transaction-level round-robin model predicts every output each cycle.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 15;
`ifdef UART_TX_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   last;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic [W-1:0]   tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic           err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .p_REQUESTERS  (N),
        .p_DATA_BITS   (W),
        .p_BUSY_TIMEOUT(T)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_data    (data),
        .i_last    (last),
        .o_ack     (ack),
        .o_grant   (grant),
        .o_tx_data (tx_data),
        .o_tx_start(tx_start),
        .i_tx_busy (tx_busy),
        .o_err     (err)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester byte queues: {last, data}
    logic [W:0] rq_mem [N][64];
    int         rq_head [N];
    int         rq_tail [N];

    // Reference model state
    int           cyc;
    int           m_ptr, m_owner, m_cur, m_idle_from, err_exp_cyc;
    bit           m_lock;
    logic [W-1:0] m_data;
    int           busy_on, busy_off;
    bit           dead_next, rand_dead;
    int           fix_d, fix_len;

    // Observations of the DUT
    int order_q[$];
    int dut_starts, first_start, last_err_cyc;

    task automatic push(input int k, input logic [W-1:0] d, input logic l);
        if (rq_head[k] == rq_tail[k]) begin
            rq_head[k] = 0;
            rq_tail[k] = 0;
        end
        rq_mem[k][rq_tail[k]] = {l, d};
        rq_tail[k]++;
    endtask

    function automatic bit all_empty();
        for (int j = 0; j < N; j++) if (rq_head[j] != rq_tail[j]) return 1'b0;
        return 1'b1;
    endfunction

    // Round-robin rule: first eligible requester after the last one served.
    function automatic int model_pick(input logic [N-1:0] r);
        logic [N-1:0] e;
        e = r;
        if (m_lock) begin
            e = '0;
            e[m_owner] = r[m_owner];
        end
        for (int i = 1; i <= N; i++) if (e[(m_ptr + i) % N]) return (m_ptr + i) % N;
        return -1;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            rq_head[j] = 0;
            rq_tail[j] = 0;
        end
        cyc = 0; m_ptr = N - 1; m_owner = 0; m_cur = 0; m_lock = 1'b0; m_data = '0;
        m_idle_from = 0; err_exp_cyc = -1; busy_on = -1; busy_off = -1;
        dead_next = 1'b0;
        req = '0; data = '0; last = '0; tx_busy = 1'b0;
    endtask

    // One cycle: observe at the falling edge, compare with the model, then drive new inputs.
    task automatic step();
        logic [N-1:0] prev_req, exp_ack, exp_grant;
        int k, d, len;
        bit dead, lst;
        @(negedge clk);
        cyc++;
        prev_req = req;
        exp_ack  = '0;
        k        = -1;
        if (cyc - 1 >= m_idle_from) k = model_pick(prev_req);
        if (k >= 0) begin
            m_cur  = k;
            m_ptr  = k;
            m_data = rq_mem[k][rq_head[k]][W-1:0];
            lst    = rq_mem[k][rq_head[k]][W];
            rq_head[k]++;
            exp_ack[k] = 1'b1;
            dead = dead_next || (rand_dead && $urandom_range(0, 7) == 0);
            dead_next = 1'b0;
            if (dead) begin
                m_idle_from = cyc + T + 1;
                err_exp_cyc = cyc + T + 1;
                busy_on     = -1;
                busy_off    = -1;
            end else begin
                d   = (fix_d > 0)   ? fix_d   : int'($urandom_range(1, 3));
                len = (fix_len > 0) ? fix_len : int'($urandom_range(1, 5));
                busy_on     = cyc + d;
                busy_off    = cyc + d + len;
                m_idle_from = cyc + d + len + 1;
            end
            m_lock  = LOCK && !lst && !dead;
            m_owner = k;
        end
        exp_grant = '0;
        if (cyc < m_idle_from) exp_grant[m_cur] = 1'b1;
        else if (m_lock)       exp_grant[m_owner] = 1'b1;

        check("tx_start", 32'(tx_start), 32'(k >= 0));
        check("ack",      32'(ack),      32'(exp_ack));
        check("grant",    32'(grant),    32'(exp_grant));
        check("tx_data",  32'(tx_data),  32'(m_data));
        check("err",      32'(err),      32'(cyc == err_exp_cyc));

        if (tx_start === 1'b1) begin
            dut_starts++;
            if (first_start < 0) first_start = cyc;
            for (int j = 0; j < N; j++) if (ack[j] === 1'b1) order_q.push_back(j);
        end
        if (err === 1'b1) last_err_cyc = cyc;

        for (int j = 0; j < N; j++) begin
            if (rq_head[j] != rq_tail[j]) begin
                req[j]         = 1'b1;
                data[j*W +: W] = rq_mem[j][rq_head[j]][W-1:0];
                last[j]        = rq_mem[j][rq_head[j]][W];
            end else begin
                req[j]         = 1'b0;
                data[j*W +: W] = '0;
                last[j]        = 1'b0;
            end
        end
        tx_busy = (cyc >= busy_on) && (cyc < busy_off);
    endtask

    task automatic drain(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            if (all_empty() && cyc > m_idle_from) break;
            step();
        end
        check("drain_done", 32'(i < max_cyc), 32'd1);
    endtask

    task automatic clear_obs();
        order_q.delete();
        dut_starts   = 0;
        first_start  = -1;
        last_err_cyc = -1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp4 [4];
        int n0;
        rand_dead = 1'b0;
        fix_d = 0;
        fix_len = 0;
        rst_n = 1'b0;
        model_reset();
        clear_obs();
        #1;
        check("rst_ack",      32'(ack),      32'd0);
        check("rst_grant",    32'(grant),    32'd0);
        check("rst_tx_data",  32'(tx_data),  32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_err",      32'(err),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, busy for 20 cycles starting 2 cycles after start
        fix_d = 2; fix_len = 20;
        clear_obs();
        push(1, 8'hA5, 1'b1);
        drain(200);
        check("single_starts", 32'(dut_starts), 32'd1);
        check("single_grant",  32'(order_q.size() > 0 ? order_q[0] : -1), 32'd1);
        check("single_errs",   32'(last_err_cyc), 32'hFFFF_FFFF);
        fix_d = 0; fix_len = 0;

        // Fairness from reset: all four requesting, 8 bytes
        do_reset();
        clear_obs();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) push(k, 8'($urandom), 1'b1);
        drain(500);
        check("fair_count", 32'(order_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < order_q.size(); i++) check("fair_order", 32'(order_q[i]), 32'(i % 4));

        // Busy timeout, then the next requester is served
        clear_obs();
        dead_next = 1'b1;
        push(2, 8'h3C, 1'b1);
        push(3, 8'hC3, 1'b1);
        drain(500);
        check("tmo_delay", 32'(last_err_cyc - first_start), 32'(T + 1));
        check("tmo_count", 32'(order_q.size()), 32'd2);
        if (order_q.size() == 2) begin
            check("tmo_first", 32'(order_q[0]), 32'd2);
            check("tmo_next",  32'(order_q[1]), 32'd3);
        end

        // Reset during WAIT_DONE
        fix_d = 2; fix_len = 20;
        n0 = dut_starts;
        push(0, 8'h5A, 1'b1);
        for (int i = 0; i < 50 && dut_starts == n0; i++) step();
        check("midrst_started", 32'(dut_starts), 32'(n0 + 1));
        repeat (5) step();
        check("midrst_pre_grant", 32'(grant), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ack",      32'(ack),      32'd0);
        check("midrst_grant",    32'(grant),    32'd0);
        check("midrst_tx_data",  32'(tx_data),  32'd0);
        check("midrst_tx_start", 32'(tx_start), 32'd0);
        check("midrst_err",      32'(err),      32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        fix_d = 0; fix_len = 0;
        clear_obs();
        for (int k = 0; k < N; k++) push(k, 8'($urandom), 1'b1);
        drain(500);
        check("midrst_first", 32'(order_q.size() > 0 ? order_q[0] : -1), 32'd0);

        // Packet lock: requester 0 sends 3 bytes, requester 1 sends 2
        do_reset();
        clear_obs();
        push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
        push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
        drain(500);
        if (LOCK) exp4 = '{0, 0, 0, 1};
        else      exp4 = '{0, 1, 0, 1};
        check("lock_count", 32'(order_q.size()), 32'd5);
        for (int i = 0; i < 4 && i < order_q.size(); i++) check("lock_order", 32'(order_q[i]), 32'(exp4[i]));

        // Randomized traffic with occasional dead transmitter
        rand_dead = 1'b1;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                for (int k = 0; k < N; k++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        int plen;
                        plen = $urandom_range(1, 3);
                        for (int b = 0; b < plen; b++) push(k, 8'($urandom), 1'(b == plen - 1));
                    end
                end
                repeat ($urandom_range(0, 10)) step();
            end
            drain(2000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
